// File: rtl/hdlc_tx_scheduler.sv
// HDLC transmit scheduler: round-robin ownership of one framer at frame boundaries,
// a one-byte staging register, eop/flag-fill control and underrun flush.
module hdlc_tx_scheduler #(
  parameter int NREQ     = 2,
  parameter int GAP_BITS = 32
) (
  input  logic              netclk,
  input  logic              reset_n,
  input  logic              fill_en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic [7:0]        fr_data_in,
  output logic              fr_data_available,
  input  logic              fr_data_consumed,
  output logic              fr_eop,
  output logic              fr_flag_fill,
  input  logic              fr_underrun,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        abort_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (GAP_BITS > 1) ? $clog2(GAP_BITS + 1) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, FLUSH, GAP} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [CW-1:0]   gap_cnt;
  logic            stg_valid;
  logic            stg_last;
  logic [7:0]      stg_data;
  logic [2:0]      cons_sync;
  logic [2:0]      urun_sync;

  logic            cons_evt;
  logic            urun_evt;
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;
  logic [NREQ-1:0] ack_one;

  // Bits [1:0] synchronise; bit 2 is the previous synchronised value for edge detection.
  assign cons_evt = cons_sync[1] & ~cons_sync[2];
  assign urun_evt = urun_sync[1] & ~urun_sync[2];

  assign g_valid = req_valid[gidx];
  assign g_last  = req_last[gidx];
  assign g_data  = req_data[8*int'(gidx) +: 8];
  assign ack_one = NREQ'(1) << gidx;

  assign fr_data_available = stg_valid;
  assign fr_data_in        = stg_data;
  assign busy              = (state != IDLE);
  assign fr_flag_fill      = fill_en && (state == IDLE) && !(|req_valid);

  // Round-robin search starting just after the last owner, wrapping around.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = ptr;
    for (int k = 1; k <= NREQ; k++) begin
      if (!pick_found && req_valid[(int'(ptr) + k) % NREQ]) begin
        pick_found = 1'b1;
        pick_idx   = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge netclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= PW'(NREQ - 1);
      gidx        <= '0;
      grant       <= '0;
      gap_cnt     <= '0;
      stg_valid   <= 1'b0;
      stg_last    <= 1'b0;
      stg_data    <= '0;
      fr_eop      <= 1'b0;
      req_ack     <= '0;
      frame_done  <= 1'b0;
      abort_count <= '0;
      cons_sync   <= '0;
      urun_sync   <= '0;
    end else begin
      cons_sync  <= {cons_sync[1:0], fr_data_consumed};
      urun_sync  <= {urun_sync[1:0], fr_underrun};
      req_ack    <= '0;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= NREQ'(1) << pick_idx;
            gidx  <= pick_idx;
            ptr   <= pick_idx;
            state <= LOAD;
          end
        end

        LOAD, STREAM: begin
          if (urun_evt) begin
            if (abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
            stg_valid <= 1'b0;
            state     <= FLUSH;
          end else if (state == STREAM && stg_valid && cons_evt) begin
            stg_valid <= 1'b0;
            if (stg_last) begin
              fr_eop  <= 1'b1;
              gap_cnt <= CW'(GAP_BITS);
              state   <= GAP;
            end
          end else if (!stg_valid && g_valid) begin
            stg_data  <= g_data;
            stg_last  <= g_last;
            stg_valid <= 1'b1;
            req_ack   <= ack_one;
            state     <= STREAM;
          end
        end

        FLUSH: begin
          // Skip the cycle right after an ack so a requester still showing the old byte is not acked twice.
          if (g_valid && !(|req_ack)) begin
            req_ack <= ack_one;
            if (g_last) begin
              gap_cnt <= CW'(GAP_BITS);
              state   <= GAP;
            end
          end
        end

        GAP: begin
          if (gap_cnt <= CW'(1)) begin
            fr_eop     <= 1'b0;
            grant      <= '0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hdlc_tx_scheduler.md
Name: hdlc_tx_scheduler

Overview:
Sequences the HDLC transmit framer and shares it between NREQ byte-stream requesters. Arbitration is round-robin and happens only at frame boundaries. The block keeps a one-byte staging register in front of the framer's byte interface and drives the framer's eop and flag-fill controls. It also handles framer underrun by flushing the rest of the aborted frame from its requester.

Parameters:
NREQ, 2, number of requesters (1..8)
GAP_BITS, 32, netclk cycles eop is held after the last byte is consumed (covers 16 FCS bits, stuffing and the closing flag)

Ports:
netclk  in  1  bit clock; all logic on posedge
reset_n  in  1  asynchronous, active-low reset
fill_en  in  1  configuration: send continuous flags when no frame is in progress
req_valid  in  NREQ  requester i has a byte presented
req_data  in  8*NREQ  byte of requester i, in bits [8i+7:8i]
req_last  in  NREQ  presented byte is the last of its frame
req_ack  out  NREQ  one-cycle pulse: presented byte taken
fr_data_in  out  8  byte to framer
fr_data_available  out  1  staging register valid
fr_data_consumed  in  1  framer took fr_data_in
fr_eop  out  1  end of packet to framer
fr_flag_fill  out  1  flag fill request to framer
fr_underrun  in  1  framer underrun flag (sticky)
grant  out  NREQ  one-hot current owner; 0 when none
busy  out  1  a frame is owned or draining
frame_done  out  1  one-cycle pulse at the end of GAP
abort_count  out  8  saturating count of underrun aborts

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, round-robin pointer=NREQ-1.
  - stg_valid=0, fr_data_in=0, fr_eop=0, req_ack=0, grant=0, busy=0, frame_done=0, abort_count=0.
- Edge detection:
  - fr_data_consumed and fr_underrun pass through 2-flop synchronisers.
  - Only their rising edges are acted on (cons_evt, urun_evt).
- fr_flag_fill = fill_en && state==IDLE && no req_valid set.
  - It drops in the same cycle a request appears, so the framer leaves flag fill at its next flag boundary.
- IDLE:
  - If any req_valid is set, grant the first requester with req_valid high, searching from pointer+1 with wrap.
  - Set grant, update pointer, go to LOAD.
- LOAD:
  - If stg_valid=0 and req_valid[g]=1: stg_data<=byte, stg_last<=req_last[g], stg_valid<=1, pulse req_ack[g]; go to STREAM.
  - Otherwise wait.
- STREAM, on cons_evt:
  - stg_valid<=0.
  - If stg_last: fr_eop<=1, gap counter<=GAP_BITS, go to GAP.
  - Otherwise refill from req_valid[g] in the same or a later cycle, with one req_ack pulse per byte.
- Requester obligation: present the next byte within 6 cycles of req_ack. A late byte is an underrun, not an error of this block.
- urun_evt in STREAM or LOAD:
  - abort_count+=1 (saturating at 255), stg_valid<=0, go to FLUSH.
- FLUSH:
  - Ack every req_valid[g] byte immediately; discard data.
  - After acking a byte with req_last set, go to GAP with fr_eop=0.
  - The framer is already sending abort/closing flag.
- GAP:
  - Decrement the counter each cycle.
  - At 0: fr_eop<=0, grant<=0, pulse frame_done, go to IDLE.
  - fr_data_available stays 0 throughout.
- Data path outputs: fr_data_available=stg_valid; fr_data_in=stg_data.
- busy = state!=IDLE.
- req_ack only ever pulses for the granted index, at most one bit per cycle.
- A single-byte frame (req_last on the first byte) goes LOAD→STREAM→GAP normally.
- Requests arriving mid-frame are held until IDLE. Simultaneous requests resolve by pointer order.
- Deassertion of a non-granted req_valid has no effect.
- Because fr_underrun is sticky, later frames see no further edge, so abort_count increments once per framer reset.
- fill_en change takes effect on the next cycle.

Test Plan:
1. Reset mid-STREAM (reset_n low 1 cycle) -> all outputs at reset values next cycle; grant=0, fr_eop=0, abort_count=0.
2. Req0 sends a 3-byte frame 0x11,0x22,0x33(last), with a framer model consuming every 8 cycles -> three req_ack[0] pulses. fr_eop rises 2 cycles after the third consume, is held 32 cycles, then frame_done pulses.
3. req_valid=2'b11 continuously, 1-byte frames -> grants alternate 01,10,01,10; no frame overlaps GAP.
4. fill_en=1, no requests -> fr_flag_fill=1. Req1 asserts -> fr_flag_fill=0 same cycle, grant=10 next cycle.
5. Req0 stalls after byte 2 and fr_underrun rises -> abort_count=1, the remaining bytes through req_last are acked and dropped, fr_eop never asserted, frame_done pulses after 32 cycles.
6. 300 underrun aborts with a framer reset between each -> abort_count saturates at 255.
